// File: rtl/motor_driver_guard_pkg.sv
// Shared definitions for the motor driver guard: register offsets within the
// guard's bus window, the dead-time channel state type and STATUS bit layout.
package motor_driver_guard_pkg;

  // Register offsets relative to GUARD_ADDRESS
  localparam logic [7:0] STATUS_OFS      = 8'd0;
  localparam logic [7:0] FAULT_COUNT_OFS = 8'd1;

  // Per-channel dead-time state
  typedef enum logic {
    DRIVE = 1'b0,
    DEAD  = 1'b1
  } chan_state_e;

  // STATUS register bit positions
  localparam int unsigned STATUS_FAULT_BIT    = 0;
  localparam int unsigned STATUS_CH0_DEAD_BIT = 1;
  localparam int unsigned STATUS_CH1_DEAD_BIT = 2;

endpackage

// File: rtl/motor_driver_guard_dead_time_channel.sv
// One H-bridge channel: a direction pair plus its PWM bit, guarded by a
// break-before-make dead time on every direction change.
//   clk, rst_n  : clock, asynchronous active-low reset
//   dir_in      : requested direction pair
//   pwm_in      : requested PWM bit
//   force_dead  : enter DEAD with a fresh count (fault clear)
//   force_off   : hold registered outputs off without disturbing the FSM
//   dir_out     : registered guarded direction pair
//   pwm_out     : registered guarded PWM bit
//   in_dead     : channel currently in DEAD
module motor_driver_guard_dead_time_channel
  import motor_driver_guard_pkg::*;
#(
  parameter logic [15:0] DEAD_CYCLES = 16'd1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dir_in,
  input  logic       pwm_in,
  input  logic       force_dead,
  input  logic       force_off,
  output logic [1:0] dir_out,
  output logic       pwm_out,
  output logic       in_dead
);

  localparam logic [15:0] LAST_COUNT = DEAD_CYCLES - 16'd1;

  chan_state_e state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  dir_out_q, dir_out_d;
  logic        pwm_out_q, pwm_out_d;
  logic        drive_on;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    if (force_dead) begin
      state_d   = DEAD;
      count_d   = '0;
      pending_d = dir_in;
    end else begin
      unique case (state_q)
        DRIVE: begin
          if (dir_in != dir_q) begin
            state_d   = DEAD;
            count_d   = '0;
            pending_d = dir_in;
          end
        end
        DEAD: begin
          if (dir_in != pending_q) begin
            // any new request restarts the full dead time
            pending_d = dir_in;
            count_d   = '0;
          end else if (count_q == LAST_COUNT) begin
            state_d = DRIVE;
            dir_d   = pending_q;
          end else begin
            count_d = count_q + 16'd1;
          end
        end
        default: begin
          state_d = DEAD;
          count_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so a direction change kills the pair
    // on the same edge that detects it.
    drive_on  = (state_d == DRIVE) && !force_off;
    dir_out_d = drive_on ? dir_d : 2'b00;
    pwm_out_d = drive_on & pwm_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DEAD;
      count_q   <= '0;
      dir_q     <= '0;
      pending_q <= '0;
      dir_out_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      dir_out_q <= dir_out_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign dir_out = dir_out_q;
  assign pwm_out = pwm_out_q;
  assign in_dead = (state_q == DEAD);

endmodule

// File: rtl/motor_driver_guard.sv
// Guard between motor_controller and the H-bridge driver pins: per-channel
// dead time, filtered/latched driver fault with output kill, and a two
// register bus window (STATUS at GUARD_ADDRESS, FAULT_COUNT at +1).
//   clk, rst_n           : clock, asynchronous active-low reset
//   din, address         : bus write data / address
//   w_en, r_en, dout     : bus strobes and registered read data
//   pwm_in, motor_in     : controller PWM and direction pairs (ch0=[1:0])
//   enable_in            : controller bridge enable
//   nfault               : asynchronous active-low driver fault
//   pwm_out, motor_out   : guarded PWM / direction pairs
//   enable_out           : guarded bridge enable
//   fault_irq            : high while a fault is latched
module motor_driver_guard
  import motor_driver_guard_pkg::*;
#(
  parameter logic [7:0]  GUARD_ADDRESS = 8'h06,
  parameter logic [15:0] DEAD_CYCLES   = 16'd1600,
  parameter logic [3:0]  FAULT_FILTER  = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [1:0] pwm_in,
  input  logic [3:0] motor_in,
  input  logic       enable_in,
  input  logic       nfault,
  output logic [1:0] pwm_out,
  output logic [3:0] motor_out,
  output logic       enable_out,
  output logic       fault_irq
);

  localparam logic [7:0] STATUS_ADDR = GUARD_ADDRESS + STATUS_OFS;
  localparam logic [7:0] FC_ADDR     = GUARD_ADDRESS + FAULT_COUNT_OFS;

  logic       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0] low_cnt_q, low_cnt_d;
  logic       fault_q, fault_d;
  logic [7:0] fault_count_q, fault_count_d;
  logic [7:0] dout_q, dout_d;
  logic       enable_q, enable_d;
  logic       fault_set, fault_clr, status_wr, fc_wr;
  logic [7:0] status;
  logic       ch0_dead, ch1_dead;
  logic       din_unused;

  // Only the clear bit of a STATUS write has meaning.
  assign din_unused = ^din[7:1];

  always_comb begin
    sync1_d = nfault;
    sync2_d = sync1_q;

    low_cnt_d = low_cnt_q;
    if (sync2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != FAULT_FILTER) begin
      low_cnt_d = low_cnt_q + 4'd1;
    end

    fault_set = (low_cnt_q == FAULT_FILTER);
    status_wr = w_en && (address == STATUS_ADDR);
    fc_wr     = w_en && (address == FC_ADDR);
    fault_clr = status_wr && din[0] && sync2_q && fault_q && !fault_set;
    fault_d   = fault_set | (fault_q & ~fault_clr);

    fault_count_d = fault_count_q;
    if (fc_wr) begin
      fault_count_d = '0;
    end else if (fault_d && !fault_q && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end

    status                      = '0;
    status[STATUS_FAULT_BIT]    = fault_q;
    status[STATUS_CH0_DEAD_BIT] = ch0_dead;
    status[STATUS_CH1_DEAD_BIT] = ch1_dead;

    dout_d = dout_q;
    if (address == STATUS_ADDR) begin
      if (r_en) dout_d = status;
    end else if (address == FC_ADDR) begin
      if (r_en) dout_d = fault_count_q;
    end else begin
      dout_d = '0;
    end

    enable_d = enable_in & ~fault_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      low_cnt_q     <= '0;
      fault_q       <= 1'b0;
      fault_count_q <= '0;
      dout_q        <= '0;
      enable_q      <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      low_cnt_q     <= low_cnt_d;
      fault_q       <= fault_d;
      fault_count_q <= fault_count_d;
      dout_q        <= dout_d;
      enable_q      <= enable_d;
    end
  end

  motor_driver_guard_dead_time_channel #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir_in    (motor_in[1:0]),
    .pwm_in    (pwm_in[0]),
    .force_dead(fault_clr),
    .force_off (fault_d),
    .dir_out   (motor_out[1:0]),
    .pwm_out   (pwm_out[0]),
    .in_dead   (ch0_dead)
  );

  motor_driver_guard_dead_time_channel #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir_in    (motor_in[3:2]),
    .pwm_in    (pwm_in[1]),
    .force_dead(fault_clr),
    .force_off (fault_d),
    .dir_out   (motor_out[3:2]),
    .pwm_out   (pwm_out[1]),
    .in_dead   (ch1_dead)
  );

  assign dout       = dout_q;
  assign enable_out = enable_q;
  assign fault_irq  = fault_q;

endmodule

// File: tb/tb_motor_driver_guard.sv
module tb_motor_driver_guard;

  localparam int DC = 4;
  localparam logic [7:0] BASE   = 8'h06;
  localparam logic [7:0] FCADDR = 8'h07;

  logic       clk, rst_n;
  logic [7:0] din, address, dout;
  logic       w_en, r_en;
  logic [1:0] pwm_in, pwm_out;
  logic [3:0] motor_in, motor_out;
  logic       enable_in, nfault, enable_out, fault_irq;

  motor_driver_guard #(
    .GUARD_ADDRESS(8'h06),
    .DEAD_CYCLES  (16'd4),
    .FAULT_FILTER (4'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .address   (address),
    .w_en      (w_en),
    .r_en      (r_en),
    .dout      (dout),
    .pwm_in    (pwm_in),
    .motor_in  (motor_in),
    .enable_in (enable_in),
    .nfault    (nfault),
    .pwm_out   (pwm_out),
    .motor_out (motor_out),
    .enable_out(enable_out),
    .fault_irq (fault_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel aims at a target pair; it drives once DC edges have passed
  // since the target last changed (or since reset / a fault clear).
  int          m_n;
  int          tlast [2];
  logic [1:0]  tgt   [2];
  logic        m_fault;
  logic [7:0]  m_fc, m_dout;
  logic [3:0]  e_mo;
  logic [1:0]  e_po;
  logic        e_eo, e_irq;
  logic        hist [$];   // nfault as sampled at edge k is hist[k-1]

  function automatic logic nf_at(int k);
    if (k < 1) return 1'b1;
    return hist[k-1];
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < 2; c++) begin
      tlast[c] = 0;
      tgt[c]   = 2'b00;
    end
    m_fault = 1'b0; m_fc = 8'h00; m_dout = 8'h00;
    e_mo = 4'h0; e_po = 2'b00; e_eo = 1'b0; e_irq = 1'b0;
    hist.delete();
  endtask

  task automatic model_step();
    int e;
    logic latch, clr, newf, drv;
    logic [7:0] st;
    logic [1:0] pair;
    e = m_n + 1;
    st = 8'h00;
    st[0] = m_fault;
    st[1] = (m_n - tlast[0]) < DC;
    st[2] = (m_n - tlast[1]) < DC;
    if (address == BASE || address == FCADDR) begin
      if (r_en) m_dout = (address == BASE) ? st : m_fc;
    end else begin
      m_dout = 8'h00;
    end
    hist.push_back(nfault);
    // fault latches once three consecutive synchronized-low samples are seen
    latch = !nf_at(e-3) && !nf_at(e-4) && !nf_at(e-5);
    clr   = !latch && m_fault && w_en && (address == BASE) && din[0] && nf_at(e-2);
    newf  = latch || (m_fault && !clr);
    if (w_en && address == FCADDR) m_fc = 8'h00;
    else if (newf && !m_fault && m_fc != 8'hFF) m_fc = m_fc + 8'd1;
    m_fault = newf;
    for (int c = 0; c < 2; c++) begin
      pair = motor_in[2*c +: 2];
      if (clr || pair != tgt[c]) begin
        tgt[c]   = pair;
        tlast[c] = e;
      end
      drv = ((e - tlast[c]) >= DC) && !m_fault;
      e_mo[2*c +: 2] = drv ? tgt[c] : 2'b00;
      e_po[c]        = drv & pwm_in[c];
    end
    e_eo  = enable_in & !m_fault;
    e_irq = m_fault;
    m_n   = e;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async", {motor_out, pwm_out, enable_out, fault_irq, dout}, 16'h0000);
    nfault = 1'b1;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] mi;
    logic [1:0] pi;
    logic       en;
    logic       rd;
    logic [7:0] addr;
    logic [3:0] mo;
    logic [1:0] po;
    logic       eo;
    logic       irq;
    logic [7:0] dq;
  } vec_t;

  vec_t vt [21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int cyc, off, burst;

    vt[0]  = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0000, 2'b00, 1'b1, 1'b0, 8'h00};
    vt[1]  = '{4'b0101, 2'b11, 1'b1, 1'b1, 8'h06, 4'b0000, 2'b00, 1'b1, 1'b0, 8'h06};
    vt[2]  = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0000, 2'b00, 1'b1, 1'b0, 8'h06};
    vt[3]  = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0000, 2'b00, 1'b1, 1'b0, 8'h06};
    vt[4]  = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0101, 2'b11, 1'b1, 1'b0, 8'h06};
    vt[5]  = '{4'b0101, 2'b11, 1'b1, 1'b1, 8'h06, 4'b0101, 2'b11, 1'b1, 1'b0, 8'h00};
    vt[6]  = '{4'b0110, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h00};
    vt[7]  = '{4'b0110, 2'b11, 1'b1, 1'b1, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[8]  = '{4'b0110, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[9]  = '{4'b0110, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[10] = '{4'b0110, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0110, 2'b11, 1'b1, 1'b0, 8'h02};
    vt[11] = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[12] = '{4'b0101, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[13] = '{4'b0111, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[14] = '{4'b0111, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[15] = '{4'b0111, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[16] = '{4'b0111, 2'b11, 1'b1, 1'b0, 8'h06, 4'b0100, 2'b10, 1'b1, 1'b0, 8'h02};
    vt[17] = '{4'b0111, 2'b01, 1'b1, 1'b0, 8'h06, 4'b0111, 2'b01, 1'b1, 1'b0, 8'h02};
    vt[18] = '{4'b0111, 2'b01, 1'b0, 1'b0, 8'h06, 4'b0111, 2'b01, 1'b0, 1'b0, 8'h02};
    vt[19] = '{4'b0111, 2'b01, 1'b1, 1'b0, 8'h20, 4'b0111, 2'b01, 1'b1, 1'b0, 8'h00};
    vt[20] = '{4'b0111, 2'b11, 1'b1, 1'b1, 8'h07, 4'b0111, 2'b11, 1'b1, 1'b0, 8'h00};

    rst_n = 1'b0;
    din = 8'h00; address = 8'h06; w_en = 1'b0; r_en = 1'b0;
    pwm_in = 2'b11; motor_in = 4'b0101; enable_in = 1'b1; nfault = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {motor_out, pwm_out, enable_out, fault_irq, dout}, 16'h0000);
    #2;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 21; i++) begin
      motor_in = vt[i].mi; pwm_in = vt[i].pi; enable_in = vt[i].en;
      r_en = vt[i].rd; address = vt[i].addr;
      step();
      check($sformatf("vec%0d", i), {motor_out, pwm_out, enable_out, fault_irq, dout},
            {vt[i].mo, vt[i].po, vt[i].eo, vt[i].irq, vt[i].dq});
    end
    r_en = 1'b0; address = BASE;

    // short glitch must not latch
    nfault = 1'b0;
    repeat (2) step();
    nfault = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("glitch_no_fault", {15'h0, fault_irq}, 16'h0000);
    end

    // sustained fault: latch 6 edges after first low sample
    nfault = 1'b0;
    cyc = 0;
    while (!fault_irq && cyc < 12) begin
      step();
      cyc++;
    end
    check("latch_latency", 16'(cyc), 16'd6);
    check("fault_outputs", {8'h00, motor_out, pwm_out, enable_out, fault_irq}, 16'h0001);

    r_en = 1'b1; address = FCADDR;
    step();
    r_en = 1'b0; address = BASE;
    check("fc_one", {8'h00, dout}, 16'h0001);

    w_en = 1'b1; din = 8'h01;
    step();
    w_en = 1'b0;
    check("clear_refused", {15'h0, fault_irq}, 16'h0001);

    nfault = 1'b1;
    repeat (4) step();
    check("fault_sticky", {15'h0, fault_irq}, 16'h0001);
    w_en = 1'b1; din = 8'h01;
    step();
    w_en = 1'b0;
    check("clear_ok", {8'h00, motor_out, pwm_out, enable_out, fault_irq}, 16'h0002);
    off = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (motor_out == 4'b0111) break;
      off++;
    end
    check("clear_dead_len", 16'(off), 16'd4);
    check("clear_restored", {10'h0, motor_out, pwm_out}, {10'h0, 4'b0111, 2'b11});

    // 256 more fault events saturate the counter
    for (int k = 0; k < 256; k++) begin
      nfault = 1'b0;
      repeat (7) step();
      nfault = 1'b1;
      repeat (4) step();
      w_en = 1'b1; address = BASE; din = 8'h01;
      step();
      w_en = 1'b0;
    end
    r_en = 1'b1; address = FCADDR;
    step();
    check("fc_saturate", {8'h00, dout}, 16'h00FF);
    address = 8'h55;
    step();
    check("unmapped_read", {8'h00, dout}, 16'h0000);
    r_en = 1'b0; w_en = 1'b1; address = FCADDR;
    step();
    w_en = 1'b0; r_en = 1'b1;
    step();
    check("fc_cleared", {8'h00, dout}, 16'h0000);
    r_en = 1'b0; address = BASE;

    // randomized traffic against the model
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) motor_in[1:0] = 2'($urandom);
      if ($urandom_range(0, 5) == 0) motor_in[3:2] = 2'($urandom);
      pwm_in = 2'($urandom);
      if ($urandom_range(0, 15) == 0) enable_in = ~enable_in;
      if (burst > 0) begin
        nfault = 1'b0;
        burst--;
      end else begin
        nfault = 1'b1;
        if ($urandom_range(0, 29) == 0) burst = int'($urandom_range(1, 7));
      end
      case ($urandom_range(0, 7))
        0, 1, 2, 3: address = BASE;
        4:          address = FCADDR;
        5:          address = 8'h05;
        6:          address = 8'h08;
        default:    address = 8'($urandom);
      endcase
      w_en = ($urandom_range(0, 7) == 0);
      r_en = 1'($urandom);
      din  = 8'($urandom);
      step();
      check("rand", {motor_out, pwm_out, enable_out, fault_irq, dout},
            {e_mo, e_po, e_eo, e_irq, m_dout});
    end
    w_en = 1'b0; r_en = 1'b0; address = BASE;

    // reset in the middle of a dead time
    motor_in = 4'b1001; enable_in = 1'b1; nfault = 1'b1;
    step();
    motor_in = 4'b1010;
    step();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_dead", {motor_out, pwm_out, enable_out, fault_irq, dout},
            {e_mo, e_po, e_eo, e_irq, m_dout});
    end

    // reset while a fault is latched
    nfault = 1'b0;
    repeat (7) step();
    check("pre_rst_fault", {15'h0, fault_irq}, 16'h0001);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_fault", {motor_out, pwm_out, enable_out, fault_irq, dout},
            {e_mo, e_po, e_eo, e_irq, m_dout});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_driver_guard.md
Name: motor_driver_guard

Overview:
- Sits between motor_controller outputs (pwm, motor, enable) and the H-bridge driver pins.
- Enforces break-before-make dead time on every per-channel direction change.
- Filters and latches the driver's active-low fault line; a latched fault forces all outputs off.
- Exposes a small status/clear register window on the same 8-bit peripheral bus.

Parameters:
- GUARD_ADDRESS, 8'h06: base bus address. STATUS = base+0, FAULT_COUNT = base+1.
- DEAD_CYCLES, 16'd1600: dead-time length in clk cycles (100 us at 16 MHz). Must be >= 1.
- FAULT_FILTER, 4'd8: consecutive synchronized-low cycles of nfault required to latch a fault.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  bus write data
- address  in  8  bus address
- w_en  in  1  bus write strobe
- r_en  in  1  bus read strobe
- dout  out  8  registered bus read data
- pwm_in  in  2  PWM from motor_controller
- motor_in  in  4  direction pairs from motor_controller; ch0 = [1:0], ch1 = [3:2]
- enable_in  in  1  bridge enable from motor_controller
- nfault  in  1  asynchronous active-low driver fault
- pwm_out  out  2  guarded PWM to bridge
- motor_out  out  4  guarded direction pairs to bridge
- enable_out  out  1  guarded bridge enable
- fault_irq  out  1  high while fault is latched

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values:
  - All outputs 0: pwm_out, motor_out, enable_out, fault_irq, dout.
  - Both channels in DEAD with count 0 and latched direction 00; fault count 0; fault clear.
- All outputs are registered. pwm_out, motor_out and enable_out lag their inputs by exactly 1 cycle in steady state.
- Per-channel FSM, states DRIVE and DEAD:
  - DRIVE:
    - motor_out pair = latched dir.
    - pwm_out[i] = pwm_in[i] & ~fault.
    - If motor_in pair != latched dir at an edge: go to DEAD, count <= 0, pending <= motor_in pair. motor_out pair and pwm_out[i] go 0 at that same edge.
  - DEAD:
    - motor_out pair = 00, pwm_out[i] = 0.
    - Each cycle: if motor_in pair != pending, then pending <= new value and count <= 0 (restart). Otherwise count++.
    - When count == DEAD_CYCLES-1 and no restart occurs: go to DRIVE, latched dir <= pending.
    - Outputs therefore stay off for exactly DEAD_CYCLES cycles after the last change.
  - Pair 11 (brake) and pair 00 (coast) are ordinary directions and are subject to dead time like any other.
- Fault filter:
  - nfault passes through a 2-FF synchronizer; a 4-bit counter counts consecutive synchronized-low cycles.
  - On reaching FAULT_FILTER, fault latches at the next edge.
  - While fault is latched:
    - enable_out = 0, pwm_out = 0, motor_out = 0, fault_irq = 1.
    - The channel FSMs keep running internally.
  - Otherwise enable_out = enable_in.
- Fault clear:
  - Writing STATUS with din[0]=1 clears fault only if synchronized nfault is high.
  - A successful clear forces both channels into DEAD with count 0.
  - A clear write in the same cycle as fault latching: the latch wins.
- FAULT_COUNT:
  - 8-bit; increments on each 0->1 transition of fault; saturates at 255.
  - Any write to FAULT_COUNT clears it. A write and an increment in the same cycle result in 0.
- Bus reads, 1-cycle latency:
  - STATUS = {5'b0, ch1_in_dead, ch0_in_dead, fault}.
  - Matching address with r_en: dout <= register value.
  - Non-matching address: dout <= 0.
  - Matching address without r_en: dout holds its value.
- Reset asserted mid-dead-time or mid-fault: immediate return to reset values; outputs stay off for a full DEAD_CYCLES after rst_n deasserts.

Decomposition:
- Shared package holds:
  - Register offsets (STATUS_OFS=0, FAULT_COUNT_OFS=1).
  - Channel state enum {DRIVE, DEAD}.
  - STATUS bit positions.
- Natural sub-module: dead_time_channel (one direction pair plus PWM bit, the FSM and the counter), instantiated twice. The top level holds the fault filter, the bus registers and the output gating.

Test Plan (DEAD_CYCLES=4, FAULT_FILTER=3):
- Release reset with motor_in=4'b0101 and pwm_in=2'b11 → motor_out=0 and pwm_out=0 for 4 cycles, then motor_out=0101 and pwm_out=11; STATUS reads 0x00.
- Ch0 changes 01→10 while in DRIVE → motor_out[1:0]=00 and pwm_out[0]=0 for exactly 4 cycles, then 10; ch1 is unaffected throughout.
- Ch0 changes 01→10, then 10→11 after 2 cycles → dead time restarts, total off time 6 cycles, final motor_out[1:0]=11.
- nfault low for 2 cycles, then high → no fault. nfault low for 3+ cycles → at latch, fault_irq=1, enable_out=0, all outputs 0, FAULT_COUNT reads 1.
- Write STATUS=0x01 while nfault is still low → fault stays set. After nfault goes high, write again → fault clears, both channels do a 4-cycle dead time, then outputs are restored.
- Force 256 fault events → FAULT_COUNT reads 255. Write FAULT_COUNT → reads 0. Read an unmapped address → dout=0 one cycle later.
